camera_ddr_writer: RTL and testbench
====================================

// Module: camera_ddr_writer
// PURPOSE
//  Downstream of camera_capture. Buffers its 64-bit pixel words (ddr_wren/ddr_data_camera) in a
//  synchronous FIFO and emits fixed-length write bursts (command + data handshakes) to the DDR
//  write port. Generates frame-buffer addresses and ping-pong selects between two frame buffers.
//  Publishes the last completed buffer for the read/display side.
// PARAMETERS
//  BURST_LEN    8          64-bit words per write burst (power of 2, >=2)
//  FIFO_DEPTH   64         input FIFO depth in words (power of 2, >= 2*BURST_LEN)
//  ADDR_W       28         byte-address width
//  FRAME_BYTES  32'h180000 bytes per frame (1024x768x16bpp); multiple of BURST_LEN*8
//  BASE0        28'h0000000  byte base address of buffer 0
//  BASE1        28'h0200000  byte base address of buffer 1
// PORTS
//  camera_pclk      in   1       sole clock; all ports synchronous to it
//  rst_n            in   1       asynchronous active-low reset
//  frame_start      in   1       1-cycle pulse at start of frame (vsync edge)
//  ddr_wren         in   1       pixel word valid (no backpressure)
//  ddr_data_camera  in   64      pixel word
//  wr_cmd_req       out  1       burst command request
//  wr_cmd_addr      out  ADDR_W  burst start byte address
//  wr_cmd_ack       in   1       command accepted this cycle
//  wr_data          out  64      burst data word
//  wr_data_valid    out  1       wr_data valid
//  wr_data_ready    in   1       sink accepts wr_data this cycle
//  frame_done       out  1       1-cycle pulse when FRAME_BYTES have been written
//  rd_buf_sel       out  1       index of last completed buffer
//  fifo_overflow    out  1       sticky: ddr_wren seen while FIFO full
//  frame_overrun    out  1       sticky: words arrived after frame complete
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; FIFO empty; wr_buf=0; addr=BASE0; byte_cnt=0; pending_start=0.
//  FIFO: write on ddr_wren when not full and frame not complete; when full, word dropped and
//   fifo_overflow set. Words arriving after frame complete are dropped and set frame_overrun.
//   Read on (wr_data_valid & wr_data_ready). Simultaneous read+write at full is allowed: write accepted.
//  FSM:
//   IDLE -> CMD when fifo_count >= BURST_LEN and no pending_start and frame not complete.
//   CMD: wr_cmd_req=1, wr_cmd_addr=addr held stable until wr_cmd_ack; on ack go to DATA.
//   DATA: wr_data_valid=1 while beat count < BURST_LEN, with wr_data = FIFO head (show-ahead).
//    Each accepted beat decrements the count; after BURST_LEN beats:
//    addr += BURST_LEN*8; byte_cnt += BURST_LEN*8; go to IDLE.
//    If byte_cnt reaches FRAME_BYTES: frame_done=1 next cycle, rd_buf_sel<=wr_buf, frame complete.
//   wr_data_valid never drops mid-burst once asserted unless the FIFO is empty (cannot occur:
//    BURST_LEN words are reserved at CMD entry).
//  frame_start:
//   Seen in IDLE: applied same cycle. Seen in CMD/DATA: latched in pending_start, applied on return to IDLE.
//   Apply: flush FIFO residue (< BURST_LEN words). If the previous frame completed,
//    wr_buf toggles; else wr_buf is reused. addr=base(wr_buf); byte_cnt=0; frame-complete cleared.
//   Words arriving in the apply cycle belong to the new frame.
//  Write path is never starved by frame_start: a burst in CMD/DATA always completes.
//  Sticky flags are cleared only by rst_n. Reset mid-burst drops the burst immediately.
// TESTING
//  1. Reset, frame_start, 8 words 0..7 -> one cmd at 0x0000000 (held until ack); data 0..7 in order;
//     next cmd at 0x0000040.
//  2. wr_data_ready toggling 1/0 during burst -> 8 beats total, no duplicate or lost word, valid held.
//  3. Full frame (196608 words) -> frame_done pulse once; rd_buf_sel=0.
//     Next frame_start -> first cmd addr 0x0200000.
//  4. frame_start during DATA with 3 residual words queued -> burst completes,
//     residue flushed, next cmd at new base.
//  5. wr_cmd_ack held 0 and 70 words pushed -> fifo_overflow=1 after 64 stored;
//     once ack given, 64 stored words are drained in order.
//  6. frame_start before frame complete -> wr_buf unchanged, addr resets to BASE0, rd_buf_sel unchanged.

Source files
------------

// File: rtl/camera_ddr_writer.sv
// camera_ddr_writer
//   Buffers 64-bit camera pixel words in a show-ahead FIFO and drains them to
//   the DDR write port as fixed-length bursts (command handshake, then data
//   beats). Frame-buffer addresses advance per burst and ping-pong between two
//   buffers across completed frames. The last completed buffer is published on
//   rd_buf_sel for the display side.
// Ports
//   camera_pclk, rst_n         : clock, asynchronous active-low reset
//   frame_start                : 1-cycle start-of-frame pulse
//   ddr_wren, ddr_data_camera  : incoming pixel words (no backpressure)
//   wr_cmd_req/addr/ack        : burst command handshake (byte address)
//   wr_data/valid/ready        : burst data handshake
//   frame_done                 : 1-cycle pulse after the last burst of a frame
//   rd_buf_sel                 : last completed buffer index
//   fifo_overflow              : sticky, word dropped because the FIFO was full
//   frame_overrun              : sticky, word dropped after frame completion
module camera_ddr_writer #(
  parameter int                BURST_LEN   = 8,
  parameter int                FIFO_DEPTH  = 64,
  parameter int                ADDR_W      = 28,
  parameter logic [31:0]       FRAME_BYTES = 32'h180000,
  parameter logic [ADDR_W-1:0] BASE0       = 28'h0000000,
  parameter logic [ADDR_W-1:0] BASE1       = 28'h0200000
) (
  input  logic              camera_pclk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              ddr_wren,
  input  logic [63:0]       ddr_data_camera,
  output logic              wr_cmd_req,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  input  logic              wr_cmd_ack,
  output logic [63:0]       wr_data,
  output logic              wr_data_valid,
  input  logic              wr_data_ready,
  output logic              frame_done,
  output logic              rd_buf_sel,
  output logic              fifo_overflow,
  output logic              frame_overrun
);

  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int BEAT_W      = $clog2(BURST_LEN);
  localparam int BURST_BYTES = BURST_LEN * 8;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t            state, state_next;
  logic [63:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [BEAT_W-1:0] beat_cnt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       byte_cnt;
  logic              wr_buf;
  logic              frame_complete;
  logic              pending_start;

  logic fifo_full, rd_en, wr_en, apply, accept_ok, last_beat, frame_end, next_buf;

  // frame_start only takes effect in IDLE so a burst in flight always finishes.
  assign apply     = (state == IDLE) && (frame_start || pending_start);
  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign rd_en     = wr_data_valid && wr_data_ready;
  // The apply cycle clears frame completion, so its word joins the new frame.
  assign accept_ok = !frame_complete || apply;
  // Apply flushes the FIFO, so a word in that cycle always fits.
  assign wr_en     = ddr_wren && accept_ok && (!fifo_full || rd_en || apply);
  assign last_beat = rd_en && (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign frame_end = last_beat && ((byte_cnt + 32'(BURST_BYTES)) == FRAME_BYTES);
  assign next_buf  = frame_complete ? ~wr_buf : wr_buf;

  assign wr_cmd_req    = (state == CMD);
  assign wr_cmd_addr   = wr_cmd_req ? addr : '0;
  assign wr_data_valid = (state == DATA) && (count != '0);
  assign wr_data       = wr_data_valid ? mem[rd_ptr] : '0;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (!apply && !frame_complete && (count >= CNT_W'(BURST_LEN)))
              state_next = CMD;
      CMD:  if (wr_cmd_ack) state_next = DATA;
      DATA: if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FIFO storage carries no reset; the pointers define what is valid.
  always_ff @(posedge camera_pclk) begin
    if (wr_en) mem[wr_ptr] <= ddr_data_camera;
  end

  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (apply) begin
      // Drop the sub-burst residue of the previous frame.
      rd_ptr <= wr_ptr;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      count  <= wr_en ? CNT_W'(1) : '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      addr           <= BASE0;
      byte_cnt       <= '0;
      wr_buf         <= 1'b0;
      frame_complete <= 1'b0;
      pending_start  <= 1'b0;
      frame_done     <= 1'b0;
      rd_buf_sel     <= 1'b0;
      fifo_overflow  <= 1'b0;
      frame_overrun  <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= frame_end;

      if (rd_en) beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);

      if (apply)
        pending_start <= 1'b0;
      else if (frame_start)
        pending_start <= 1'b1;

      if (apply) begin
        wr_buf         <= next_buf;
        addr           <= next_buf ? BASE1 : BASE0;
        byte_cnt       <= '0;
        frame_complete <= 1'b0;
      end else if (last_beat) begin
        addr     <= addr + ADDR_W'(BURST_BYTES);
        byte_cnt <= byte_cnt + 32'(BURST_BYTES);
        if (frame_end) begin
          frame_complete <= 1'b1;
          rd_buf_sel     <= wr_buf;
        end
      end

      if (ddr_wren && accept_ok && fifo_full && !rd_en && !apply)
        fifo_overflow <= 1'b1;
      if (ddr_wren && frame_complete && !apply)
        frame_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_camera_ddr_writer.sv
// Testbench for camera_ddr_writer. A queue-based reference model tracks which
// words the writer must accept, the order they leave on the burst port, the
// expected burst addresses, frame completion, buffer selection and the sticky
// flags. A reduced frame size keeps a full frame short.
module tb_camera_ddr_writer;

  localparam int          BURST = 8;
  localparam int          DEPTH = 64;
  localparam logic [31:0] FB    = 32'h800;   // 256 words per frame
  localparam logic [27:0] B0    = 28'h0000000;
  localparam logic [27:0] B1    = 28'h0200000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs, wren, ack, ready;
  logic [63:0] din;
  logic        wr_cmd_req, wr_data_valid, frame_done, rd_buf_sel;
  logic        fifo_overflow, frame_overrun;
  logic [27:0] wr_cmd_addr;
  logic [63:0] wr_data;

  camera_ddr_writer #(
    .BURST_LEN(BURST), .FIFO_DEPTH(DEPTH), .ADDR_W(28),
    .FRAME_BYTES(FB), .BASE0(B0), .BASE1(B1)
  ) dut (
    .camera_pclk(clk), .rst_n(rst_n), .frame_start(fs),
    .ddr_wren(wren), .ddr_data_camera(din),
    .wr_cmd_req(wr_cmd_req), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_ack(ack),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(ready),
    .frame_done(frame_done), .rd_buf_sel(rd_buf_sel),
    .fifo_overflow(fifo_overflow), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] q[$];
  logic [27:0] exp_addr, last_ack_addr;
  bit          in_burst, pending, complete, wbuf;
  bit          exp_done, exp_rd, exp_ovf, exp_ovr;
  int          beats, frame_bytes, pops, done_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_addr = B0; in_burst = 0; pending = 0; complete = 0; wbuf = 0;
    exp_done = 0; exp_rd = 0; exp_ovf = 0; exp_ovr = 0;
    beats = 0; frame_bytes = 0;
  endtask

  // One clock: drive inputs, check current outputs, advance the model.
  task automatic step(input bit fs_i, input bit wren_i, input logic [63:0] din_i,
                      input bit ack_i, input bit ready_i);
    bit idle, apply, pop, cmp0, full0, done_n, rd_n;
    fs = fs_i; wren = wren_i; din = din_i; ack = ack_i; ready = ready_i;
    #1;
    chk("frame_done", frame_done, exp_done);
    chk("rd_buf_sel", rd_buf_sel, exp_rd);
    chk("fifo_overflow", fifo_overflow, exp_ovf);
    chk("frame_overrun", frame_overrun, exp_ovr);
    if (frame_done === 1'b1) done_seen++;
    idle   = !wr_cmd_req && !in_burst;
    apply  = idle && (pending || fs_i);
    pop    = wr_data_valid && ready_i;
    cmp0   = complete;
    full0  = (q.size() >= DEPTH);
    done_n = 0;
    rd_n   = exp_rd;
    if (wr_cmd_req) chk("cmd_addr", wr_cmd_addr, exp_addr);
    if (wr_cmd_req && ack_i) begin
      last_ack_addr = wr_cmd_addr;
      in_burst = 1; beats = 0;
      exp_addr = exp_addr + 28'(BURST * 8);
    end
    if (pop) begin
      pops++;
      if (q.size() == 0) begin
        checks++; failures++;
        $error("FAIL wr_data observed=%h expected=<no word queued>", wr_data);
      end else begin
        chk("wr_data", wr_data, q.pop_front());
      end
      beats++; frame_bytes += 8;
      if (beats == BURST) begin
        in_burst = 0;
        if (frame_bytes == int'(FB)) begin
          complete = 1; done_n = 1; rd_n = wbuf;
        end
      end
    end
    if (apply) begin
      q.delete();
      if (cmp0) wbuf = ~wbuf;
      exp_addr = wbuf ? B1 : B0;
      frame_bytes = 0; complete = 0; pending = 0;
    end else if (fs_i) begin
      pending = 1;
    end
    if (wren_i) begin
      if (cmp0 && !apply) exp_ovr = 1;
      else if (apply || !full0 || pop) q.push_back(din_i);
      else exp_ovf = 1;
    end
    @(posedge clk); #1;
    exp_done = done_n;
    exp_rd = rd_n;
  endtask

  initial begin
    int cyc;
    int pops0;
    logic [63:0] w;
    rst_n = 0; fs = 0; wren = 0; din = '0; ack = 0; ready = 0;
    pops = 0; done_seen = 0; last_ack_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_req", wr_cmd_req, 1'b0);
    chk("rst_cmd_addr", wr_cmd_addr, 28'h0);
    chk("rst_data_valid", wr_data_valid, 1'b0);
    chk("rst_data", wr_data, 64'h0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_rd_buf_sel", rd_buf_sel, 1'b0);
    chk("rst_overflow", fifo_overflow, 1'b0);
    chk("rst_overrun", frame_overrun, 1'b0);
    rst_n = 1;
    @(posedge clk); #1;

    // Words 0..7 after frame_start; command held while ack is low.
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 64'(i), 0, 0);
    repeat (5) step(0, 0, '0, 0, 0);
    chk("cmd_held", wr_cmd_req, 1'b1);
    step(0, 0, '0, 1, 0);
    repeat (10) step(0, 0, '0, 0, 1);
    chk("first_cmd_addr", last_ack_addr, 28'h0000000);
    for (int i = 0; i < 8; i++) step(0, 1, {$urandom, $urandom}, 1, 1);
    repeat (15) step(0, 0, '0, 1, 1);
    chk("second_cmd_addr", last_ack_addr, 28'h0000040);

    // Sink ready toggling every cycle during a burst.
    for (int i = 0; i < 8; i++) step(0, 1, {$urandom, $urandom}, 1, 0);
    for (int i = 0; i < 24; i++) step(0, 0, '0, 1, 1'(i % 2));
    chk("beats_after_toggle", 64'(pops), 64'd24);

    // Random traffic until the frame completes.
    cyc = 0;
    while (!exp_done && cyc < 4000) begin
      w = {$urandom, $urandom};
      step(0, $urandom_range(0, 9) < 4, w, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      cyc++;
    end
    chk("frame_within_budget", 64'(exp_done), 64'd1);
    step(0, 1, {$urandom, $urandom}, 0, 0);
    step(0, 1, {$urandom, $urandom}, 0, 0);
    chk("frame_done_count", 64'(done_seen), 64'd1);
    chk("rd_buf_after_frame", rd_buf_sel, 1'b0);
    chk("overrun_after_frame", frame_overrun, 1'b1);

    // Next frame goes to buffer 1.
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, {$urandom, $urandom}, 1, 1);
    repeat (15) step(0, 0, '0, 1, 1);
    chk("buf1_cmd_addr", last_ack_addr, B1);

    // frame_start mid-burst with 3 residual words; unfinished frame reuses buffer 1.
    for (int i = 0; i < 11; i++) step(0, 1, {$urandom, $urandom}, 1, 0);
    chk("in_data_phase", wr_data_valid, 1'b1);
    step(1, 0, '0, 1, 0);
    repeat (15) step(0, 0, '0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 1, {$urandom, $urandom}, 1, 1);
    repeat (15) step(0, 0, '0, 1, 1);
    chk("reuse_cmd_addr", last_ack_addr, B1);
    chk("rd_buf_unchanged", rd_buf_sel, 1'b0);

    // Command stalled: 70 words pushed, 64 stored, then drained in order.
    for (int i = 0; i < 70; i++) step(0, 1, {$urandom, $urandom}, 0, 1);
    chk("overflow_set", fifo_overflow, 1'b1);
    pops0 = pops;
    repeat (110) step(0, 0, '0, 1, 1);
    chk("drained_words", 64'(pops - pops0), 64'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
